// File: rtl/pdua_control_unit.sv
// Hardwired fetch/decode/execute sequencer for the PDUA datapath.
// Define PDUA_CU_SINGLE_STEP_EN to add a step input that pauses after every instruction.
module pdua_control_unit #(
    parameter int unsigned           ADDR_WIDTH = 3,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 3'b000,
    parameter logic [ADDR_WIDTH-1:0] TMP_ADDR   = 3'b110,
    parameter logic [ADDR_WIDTH-1:0] ACC_ADDR   = 3'b111,
    parameter logic [2:0]            SEL_PASS   = 3'b110,
    parameter logic [2:0]            SEL_INC    = 3'b101,
    parameter logic [1:0]            SHAMT_DEF  = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            out_IR,
    input  logic                  C,
    input  logic                  N,
    input  logic                  P,
    input  logic                  Z,
    input  logic                  mem_ready,
`ifdef PDUA_CU_SINGLE_STEP_EN
    input  logic                  step,
`endif
    output logic                  wr_rdn,
    output logic                  enaf,
    output logic [2:0]            selop,
    output logic [1:0]            shamt,
    output logic                  bank_wr_en,
    output logic [ADDR_WIDTH-1:0] BusB_addr,
    output logic [ADDR_WIDTH-1:0] BusC_addr,
    output logic                  sclr,
    output logic                  ir_en,
    output logic                  mar_en,
    output logic                  mdr_en,
    output logic                  mdr_alu_n,
    output logic                  halted,
    output logic                  illegal
);

    typedef enum logic [4:0] {
        StInit, StClr, StF0, StF1, StF2, StDec,
        StO0, StO1, StLd0, StLd1, StLd2, StLd3,
        StSt0, StSt1, StSt2, StJmp, StAlu, StIll, StHalt, StPause
    } state_e;

    typedef enum logic [1:0] {OpLda, OpSta, OpJmp} op_e;

`ifdef PDUA_CU_SINGLE_STEP_EN
    localparam state_e DoneSt = StPause;
`else
    localparam state_e DoneSt = StF0;
`endif

    state_e     state_q;
    op_e        op_q;
    logic       take_q;
    logic [2:0] alu_sel_q;

    logic unused_flags;
    assign unused_flags = C ^ P;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StInit;
            op_q      <= OpLda;
            take_q    <= 1'b0;
            alu_sel_q <= 3'b000;
        end else begin
            case (state_q)
                StInit: state_q <= StClr;
                StClr:  state_q <= StF0;
                StF0:   state_q <= StF1;
                StF1:   if (mem_ready) state_q <= StF2;
                StF2:   state_q <= StDec;
                StDec: begin
                    alu_sel_q <= out_IR[2:0];
                    casez (out_IR)
                        5'b00000: state_q <= DoneSt;
                        5'b00001: begin op_q <= OpLda; state_q <= StO0; end
                        5'b00010: begin op_q <= OpSta; state_q <= StO0; end
                        5'b00011: begin op_q <= OpJmp; take_q <= 1'b1; state_q <= StO0; end
                        5'b00100: begin op_q <= OpJmp; take_q <= Z;    state_q <= StO0; end
                        5'b00101: begin op_q <= OpJmp; take_q <= N;    state_q <= StO0; end
                        5'b01???: state_q <= StAlu;
                        5'b11111: state_q <= StHalt;
                        default:  state_q <= StIll;
                    endcase
                end
                StO0: state_q <= StO1;
                StO1: begin
                    // Operand word is in MDR once this read completes
                    if (mem_ready) begin
                        case (op_q)
                            OpLda:   state_q <= StLd0;
                            OpSta:   state_q <= StSt0;
                            default: state_q <= take_q ? StJmp : DoneSt;
                        endcase
                    end
                end
                StLd0:  state_q <= StLd1;
                StLd1:  state_q <= StLd2;
                StLd2:  if (mem_ready) state_q <= StLd3;
                StLd3:  state_q <= DoneSt;
                StSt0:  state_q <= StSt1;
                StSt1:  state_q <= StSt2;
                StSt2:  if (mem_ready) state_q <= DoneSt;
                StJmp:  state_q <= DoneSt;
                StAlu:  state_q <= DoneSt;
                StIll:  state_q <= DoneSt;
                StHalt: state_q <= StHalt;
`ifdef PDUA_CU_SINGLE_STEP_EN
                StPause: if (step) state_q <= StF0;
`else
                StPause: state_q <= StF0;
`endif
                default: state_q <= StInit;
            endcase
        end
    end

    always_comb begin
        wr_rdn     = 1'b0;
        enaf       = 1'b0;
        selop      = 3'b000;
        shamt      = 2'b00;
        bank_wr_en = 1'b0;
        BusB_addr  = '0;
        BusC_addr  = '0;
        sclr       = 1'b0;
        ir_en      = 1'b0;
        mar_en     = 1'b0;
        mdr_en     = 1'b0;
        mdr_alu_n  = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            StClr: sclr = 1'b1;
            StF0, StO0: begin
                BusB_addr = PC_ADDR;
                selop     = SEL_PASS;
                mar_en    = 1'b1;
            end
            StF1, StO1: begin
                mdr_en = 1'b1;
                // PC advances only on the completing cycle so it moves exactly once
                if (mem_ready) begin
                    BusB_addr  = PC_ADDR;
                    BusC_addr  = PC_ADDR;
                    selop      = SEL_INC;
                    bank_wr_en = 1'b1;
                end
            end
            StF2: ir_en = 1'b1;
            StLd0, StSt0: begin
                BusC_addr  = TMP_ADDR;
                mdr_alu_n  = 1'b1;
                bank_wr_en = 1'b1;
            end
            StLd1, StSt1: begin
                BusB_addr = TMP_ADDR;
                selop     = SEL_PASS;
                mar_en    = 1'b1;
            end
            StLd2: mdr_en = 1'b1;
            StLd3: begin
                BusC_addr  = ACC_ADDR;
                mdr_alu_n  = 1'b1;
                bank_wr_en = 1'b1;
            end
            StSt2: begin
                BusB_addr = ACC_ADDR;
                selop     = SEL_PASS;
                wr_rdn    = 1'b1;
            end
            StJmp: begin
                BusC_addr  = PC_ADDR;
                mdr_alu_n  = 1'b1;
                bank_wr_en = 1'b1;
            end
            StAlu: begin
                BusB_addr  = ACC_ADDR;
                BusC_addr  = ACC_ADDR;
                selop      = alu_sel_q;
                shamt      = SHAMT_DEF;
                enaf       = 1'b1;
                bank_wr_en = 1'b1;
            end
            StIll:  illegal = 1'b1;
            StHalt: halted  = 1'b1;
            default: ;
        endcase
    end

endmodule
